// File: rtl/musa_loader_pkg.sv
// musa_loader_pkg: loader FSM states and command byte encodings.
package musa_loader_pkg;
    typedef enum logic [1:0] {S_CMD, S_HDR, S_DATA, S_CSUM} state_t;
    localparam logic [7:0] CMD_LOAD_I = 8'h01;
    localparam logic [7:0] CMD_LOAD_D = 8'h02;
    localparam logic [7:0] CMD_RUN    = 8'h03;
    function automatic logic is_load(input logic [7:0] b);
        return b == CMD_LOAD_I || b == CMD_LOAD_D;
    endfunction
endpackage

// File: rtl/musa_prog_loader_if.sv
// musa_prog_loader_if: host byte stream in, memory write port and core control out.
interface musa_prog_loader_if #(parameter int ADDR_WIDTH = 16, parameter int DATA_WIDTH = 32);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  imem_we;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  cpu_rst_n;
    logic                  busy;
    logic                  err;
    modport master (output in_data, in_valid,
                    input in_ready, imem_we, dmem_we, mem_addr, mem_wdata, cpu_rst_n, busy, err);
    modport slave (input in_data, in_valid,
                   output in_ready, imem_we, dmem_we, mem_addr, mem_wdata, cpu_rst_n, busy, err);
endinterface

// File: rtl/musa_word_packer.sv
// musa_word_packer: assembles big-endian words from bytes, pulses word_valid the cycle after byte 4.
module musa_word_packer #(parameter int DATA_WIDTH = 32) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_in,
    output logic                  word_last,
    output logic                  word_valid,
    output logic [DATA_WIDTH-1:0] word
);
    logic [DATA_WIDTH-9:0] sh;
    logic [1:0]            bc;
    assign word_last = bc == 2'd3;
    always_ff @(posedge clk) begin
        if (rst) begin
            sh         <= '0;
            bc         <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= byte_valid && word_last;
            if (byte_valid) begin
                sh <= {sh[DATA_WIDTH-17:0], byte_in};
                bc <= bc + 2'd1;
                if (word_last) word <= {sh, byte_in};
            end
        end
    end
endmodule

// File: rtl/musa_prog_loader.sv
// musa_prog_loader: parses load/run byte frames and writes imem/dmem while holding the core in reset.
// Optional trailing XOR checksum byte enabled by defining MUSA_LOADER_CSUM_EN.
module musa_prog_loader
    import musa_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input logic              clk,
    input logic              rst,
    musa_prog_loader_if.slave bus
);
`ifdef MUSA_LOADER_CSUM_EN
    localparam state_t S_END = S_CSUM;
    logic [7:0] csum;
`else
    localparam state_t S_END = S_CMD;
`endif
    state_t                state, state_n;
    logic [1:0]            hcnt;
    logic [23:0]           hdr;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  is_d, run, err, acc, word_last, word_valid;
    logic [15:0]           hdr_cnt;
    assign acc           = bus.in_valid;
    assign hdr_cnt       = {hdr[7:0], bus.in_data};
    assign bus.in_ready  = 1'b1;
    assign bus.imem_we   = word_valid && !is_d;
    assign bus.dmem_we   = word_valid && is_d;
    assign bus.cpu_rst_n = !rst && run;
    assign bus.busy      = state != S_CMD;
    assign bus.err       = err;
    musa_word_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
        .clk       (clk),
        .rst       (rst),
        .byte_valid(acc && state == S_DATA),
        .byte_in   (bus.in_data),
        .word_last (word_last),
        .word_valid(word_valid),
        .word      (bus.mem_wdata)
    );
    always_comb begin
        state_n = state;
        case (state)
            S_CMD:  if (acc && is_load(bus.in_data)) state_n = S_HDR;
            S_HDR:  if (acc && hcnt == 2'd3) state_n = hdr_cnt == '0 ? S_END : S_DATA;
            S_DATA: if (acc && word_last && cnt == CNT_WIDTH'(1)) state_n = S_END;
            default: if (acc) state_n = S_CMD;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_CMD;
            hcnt     <= '0;
            hdr      <= '0;
            waddr    <= '0;
            cnt      <= '0;
            is_d     <= 1'b0;
            run      <= 1'b0;
            err      <= 1'b0;
            bus.mem_addr <= '0;
`ifdef MUSA_LOADER_CSUM_EN
            csum     <= '0;
`endif
        end else begin
            state <= state_n;
            if (acc) begin
                case (state)
                    S_CMD: begin
                        // loads re-halt the core; RUN releases it; anything else is flagged
                        if (is_load(bus.in_data)) begin
                            is_d <= bus.in_data == CMD_LOAD_D;
                            run  <= 1'b0;
                            err  <= 1'b0;
`ifdef MUSA_LOADER_CSUM_EN
                            csum <= '0;
`endif
                        end else if (bus.in_data == CMD_RUN) begin
                            run <= 1'b1;
                            err <= 1'b0;
                        end else err <= 1'b1;
                    end
                    S_HDR: begin
                        hcnt <= hcnt + 2'd1;
                        hdr  <= {hdr[15:0], bus.in_data};
                        if (hcnt == 2'd3) begin
                            waddr <= ADDR_WIDTH'(hdr[23:8]);
                            cnt   <= CNT_WIDTH'(hdr_cnt);
                        end
                    end
                    S_DATA: begin
`ifdef MUSA_LOADER_CSUM_EN
                        csum <= csum ^ bus.in_data;
`endif
                        if (word_last) begin
                            bus.mem_addr <= waddr;
                            waddr        <= waddr + ADDR_WIDTH'(1);
                            cnt          <= cnt - CNT_WIDTH'(1);
                        end
                    end
                    default: begin
`ifdef MUSA_LOADER_CSUM_EN
                        if (bus.in_data != csum) err <= 1'b1;
`endif
                    end
                endcase
            end
        end
    end
endmodule
